// File: rtl/elevator_scan_controller.sv
// Multi-floor SCAN elevator controller: latches floor calls, serves them in
// the current direction until none remain ahead, then reverses.
module elevator_scan_controller #(
  parameter int unsigned NUM_FLOORS   = 8,
  parameter int unsigned FLOOR_W      = 4,
  parameter int unsigned TRAVEL_TICKS = 10,
  parameter int unsigned DOOR_TICKS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  idle
);

  localparam int unsigned TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int unsigned DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR} state_t;

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d, nf;
  logic                    dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   pend_q, clr, pr, cur_oh, nf_oh;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [DW-1:0]           dcnt_q, dcnt_d;
  logic                    here, above, below, nf_above, nf_below;
  logic                    pick_up, pick_dn;

  // Floors strictly above f. Shift/mask form avoids indexing pending with a
  // floor index that may be wider than the vector needs.
  function automatic logic [NUM_FLOORS-1:0] mask_above(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) > f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] mask_below(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) < f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    return NUM_FLOORS'(1) << f;
  endfunction

  // Next-state, counters, direction and call-clear decode.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    clr     = '0;

    pr       = pend_q | req;
    cur_oh   = onehot(floor_q);
    here     = |(pend_q & cur_oh);
    above    = |(pend_q & mask_above(floor_q));
    below    = |(pend_q & mask_below(floor_q));
    nf       = (state_q == S_MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    nf_oh    = onehot(nf);
    nf_above = |(pend_q & mask_above(nf));
    nf_below = |(pend_q & mask_below(nf));
    // Keep the current preference when it has work, otherwise take the other side.
    pick_up  = above && (dir_q || !below);
    pick_dn  = below && (!dir_q || !above);

    case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d = S_DOOR;
          dcnt_d  = '0;
          clr     = cur_oh;
        end else if (pick_up) begin
          state_d = S_MOVE_UP;
          dir_d   = 1'b1;
          tcnt_d  = '0;
        end else if (pick_dn) begin
          state_d = S_MOVE_DOWN;
          dir_d   = 1'b0;
          tcnt_d  = '0;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (tcnt_q == T_LAST) begin
          floor_d = nf;
          tcnt_d  = '0;
          if (|(pr & nf_oh)) begin
            state_d = S_DOOR;
            dcnt_d  = '0;
            clr     = nf_oh;
          end else if (state_q == S_MOVE_UP ? nf_above : nf_below) begin
            state_d = state_q;
          end else if (state_q == S_MOVE_UP ? nf_below : nf_above) begin
            state_d = (state_q == S_MOVE_UP) ? S_MOVE_DOWN : S_MOVE_UP;
            dir_d   = (state_q != S_MOVE_UP);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DOOR: begin
        clr = cur_oh;
        if (|(req & cur_oh)) begin
          dcnt_d = '0;
        end else if (dcnt_q == D_LAST) begin
          if (pick_up) begin
            state_d = S_MOVE_UP;
            dir_d   = 1'b1;
            tcnt_d  = '0;
          end else if (pick_dn) begin
            state_d = S_MOVE_DOWN;
            dir_d   = 1'b0;
            tcnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, position, direction, counters and pending-call register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      pend_q  <= '0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= (pend_q | req) & ~clr;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign pending       = pend_q;
  assign current_floor = floor_q;
  assign dir_up        = dir_q;
  assign moving        = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
  assign door_open     = (state_q == S_DOOR);
  assign idle          = (state_q == S_IDLE);

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scoreboard bench for elevator_scan_controller: stimulus queues expected
// output values tagged with the clock edge after which they must hold; a
// monitor checks them on the falling edge.
module tb_elevator_scan_controller;

  localparam int SIG_FLOOR = 0;
  localparam int SIG_PEND  = 1;
  localparam int SIG_DIR   = 2;
  localparam int SIG_MOV   = 3;
  localparam int SIG_DOOR  = 4;
  localparam int SIG_IDLE  = 5;

  typedef struct {
    int    when;
    int    sig;
    int    val;
    string name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] pending;
  logic [3:0] current_floor;
  logic       dir_up, moving, door_open, idle;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  elevator_scan_controller #(
    .NUM_FLOORS(8), .FLOOR_W(4), .TRAVEL_TICKS(10), .DOOR_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .pending(pending),
    .current_floor(current_floor), .dir_up(dir_up), .moving(moving),
    .door_open(door_open), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int sig);
    case (sig)
      SIG_FLOOR: return int'(current_floor);
      SIG_PEND:  return int'(pending);
      SIG_DIR:   return int'(dir_up);
      SIG_MOV:   return int'(moving);
      SIG_DOOR:  return int'(door_open);
      default:   return int'(idle);
    endcase
  endfunction

  // Monitor: retire every expectation that has come due.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].when <= cyc) begin
        checks++;
        if (actual(sbq[i].sig) != sbq[i].val) begin
          errors++;
          $display("FAIL %s after edge %0d: got 0x%0h, expected 0x%0h",
                   sbq[i].name, cyc, actual(sbq[i].sig), sbq[i].val);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic exp_at(input int when, input int sig, input int val, input string name);
    exp_t e;
    e.when = when; e.sig = sig; e.val = val; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Drive req before the next edge; k is that edge.
  task automatic start_pulse(input logic [7:0] mask, output int k);
    @(negedge clk);
    req = mask;
    k = cyc + 1;
  endtask

  task automatic end_pulse();
    @(negedge clk);
    req = '0;
  endtask

  task automatic do_reset(input string tag);
    int r;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r = cyc + 1;
    exp_at(r, SIG_FLOOR, 0, {tag, "_floor"});
    exp_at(r, SIG_PEND,  0, {tag, "_pend"});
    exp_at(r, SIG_DIR,   1, {tag, "_dir"});
    exp_at(r, SIG_MOV,   0, {tag, "_mov"});
    exp_at(r, SIG_DOOR,  0, {tag, "_door"});
    exp_at(r, SIG_IDLE,  1, {tag, "_idle"});
    wait_until(r + 1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_at(cyc + 1, SIG_FLOOR, 0, "rst_floor");
    exp_at(cyc + 1, SIG_PEND,  0, "rst_pend");
    exp_at(cyc + 1, SIG_DIR,   1, "rst_dir");
    exp_at(cyc + 1, SIG_IDLE,  1, "rst_idle");
    exp_at(cyc + 1, SIG_DOOR,  0, "rst_door");
    exp_at(cyc + 1, SIG_MOV,   0, "rst_mov");
    wait_until(cyc + 2);

    // 1: call at the current floor opens the door without a move.
    start_pulse(8'h01, k);
    exp_at(k,     SIG_PEND,  8'h01, "s1_pend_latched");
    exp_at(k,     SIG_DOOR,  0,     "s1_door_pre");
    exp_at(k + 1, SIG_DOOR,  1,     "s1_door_open");
    exp_at(k + 1, SIG_PEND,  0,     "s1_pend_cleared");
    exp_at(k + 4, SIG_DOOR,  1,     "s1_door_last");
    exp_at(k + 4, SIG_PEND,  0,     "s1_pend_held0");
    exp_at(k + 5, SIG_DOOR,  0,     "s1_door_closed");
    exp_at(k + 5, SIG_IDLE,  1,     "s1_idle");
    exp_at(k + 5, SIG_FLOOR, 0,     "s1_floor");
    end_pulse();
    wait_until(k + 6);

    // 2: single call five floors up.
    start_pulse(8'h20, k);
    exp_at(k + 1,  SIG_MOV,   1,     "s2_moving");
    exp_at(k + 10, SIG_FLOOR, 0,     "s2_floor_pre");
    exp_at(k + 11, SIG_FLOOR, 1,     "s2_floor1");
    exp_at(k + 50, SIG_FLOOR, 4,     "s2_floor4");
    exp_at(k + 50, SIG_PEND,  8'h20, "s2_pend_travel");
    exp_at(k + 51, SIG_FLOOR, 5,     "s2_floor5");
    exp_at(k + 51, SIG_DOOR,  1,     "s2_door");
    exp_at(k + 51, SIG_MOV,   0,     "s2_stopped");
    exp_at(k + 51, SIG_PEND,  0,     "s2_pend_clr");
    exp_at(k + 54, SIG_DOOR,  1,     "s2_door_last");
    exp_at(k + 55, SIG_DOOR,  0,     "s2_door_closed");
    exp_at(k + 55, SIG_IDLE,  1,     "s2_idle");
    end_pulse();
    wait_until(k + 56);

    // 3: park at floor 3 heading up, then calls on both sides at once.
    do_reset("r3");
    start_pulse(8'h08, k);
    exp_at(k + 31, SIG_FLOOR, 3, "s3_park_floor");
    exp_at(k + 35, SIG_IDLE,  1, "s3_park_idle");
    exp_at(k + 35, SIG_DIR,   1, "s3_park_dir");
    end_pulse();
    wait_until(k + 36);
    start_pulse(8'h42, k);
    exp_at(k,      SIG_PEND,  8'h42, "s3_both_latched");
    exp_at(k + 1,  SIG_DIR,   1,     "s3_dir_up");
    exp_at(k + 31, SIG_FLOOR, 6,     "s3_first_floor6");
    exp_at(k + 31, SIG_DOOR,  1,     "s3_door6");
    exp_at(k + 31, SIG_PEND,  8'h02, "s3_pend_after6");
    exp_at(k + 34, SIG_DOOR,  1,     "s3_door6_last");
    exp_at(k + 35, SIG_MOV,   1,     "s3_reverse_mov");
    exp_at(k + 35, SIG_DIR,   0,     "s3_reverse_dir");
    exp_at(k + 60, SIG_DIR,   0,     "s3_dir_down_travel");
    exp_at(k + 65, SIG_FLOOR, 3,     "s3_pass3");
    exp_at(k + 85, SIG_FLOOR, 1,     "s3_floor1");
    exp_at(k + 85, SIG_DOOR,  1,     "s3_door1");
    exp_at(k + 85, SIG_PEND,  0,     "s3_pend_done");
    exp_at(k + 89, SIG_IDLE,  1,     "s3_idle");
    exp_at(k + 89, SIG_DIR,   0,     "s3_dir_final");
    end_pulse();
    wait_until(k + 90);

    // 4: call ahead made en route is served on the pass.
    do_reset("r4");
    start_pulse(8'h40, k);
    exp_at(k + 25, SIG_PEND,  8'h50, "s4_pend_both");
    exp_at(k + 40, SIG_FLOOR, 3,     "s4_floor3");
    exp_at(k + 40, SIG_MOV,   1,     "s4_mov3");
    exp_at(k + 41, SIG_FLOOR, 4,     "s4_floor4");
    exp_at(k + 41, SIG_DOOR,  1,     "s4_door4");
    exp_at(k + 41, SIG_PEND,  8'h40, "s4_pend_stop");
    exp_at(k + 44, SIG_PEND,  8'h40, "s4_pend_stop_end");
    exp_at(k + 45, SIG_MOV,   1,     "s4_resume");
    exp_at(k + 45, SIG_DIR,   1,     "s4_resume_dir");
    exp_at(k + 65, SIG_FLOOR, 6,     "s4_floor6");
    exp_at(k + 65, SIG_DOOR,  1,     "s4_door6");
    exp_at(k + 65, SIG_PEND,  0,     "s4_pend_done");
    exp_at(k + 69, SIG_IDLE,  1,     "s4_idle");
    end_pulse();
    wait_until(k + 24);
    req = 8'h10;
    end_pulse();
    wait_until(k + 70);

    // 5: call behind the travel direction waits for reversal.
    do_reset("r5");
    start_pulse(8'h40, k);
    exp_at(k + 45,  SIG_PEND,  8'h44, "s5_pend_both");
    exp_at(k + 61,  SIG_FLOOR, 6,     "s5_floor6");
    exp_at(k + 61,  SIG_DOOR,  1,     "s5_door6");
    exp_at(k + 61,  SIG_PEND,  8'h04, "s5_pend_wait");
    exp_at(k + 65,  SIG_DIR,   0,     "s5_rev_dir");
    exp_at(k + 65,  SIG_MOV,   1,     "s5_rev_mov");
    exp_at(k + 104, SIG_FLOOR, 3,     "s5_floor3");
    exp_at(k + 104, SIG_PEND,  8'h04, "s5_pend_held");
    exp_at(k + 105, SIG_FLOOR, 2,     "s5_floor2");
    exp_at(k + 105, SIG_DOOR,  1,     "s5_door2");
    exp_at(k + 105, SIG_PEND,  0,     "s5_pend_done");
    exp_at(k + 109, SIG_IDLE,  1,     "s5_idle");
    end_pulse();
    wait_until(k + 44);
    req = 8'h04;
    end_pulse();
    wait_until(k + 110);

    // 6a: asynchronous reset in mid-travel.
    do_reset("r6");
    start_pulse(8'h80, k);
    exp_at(k + 33, SIG_FLOOR, 3,     "s6_floor3");
    exp_at(k + 33, SIG_PEND,  8'h80, "s6_pend");
    exp_at(k + 33, SIG_MOV,   1,     "s6_mov");
    exp_at(k + 34, SIG_FLOOR, 0,     "s6_async_floor");
    exp_at(k + 34, SIG_PEND,  0,     "s6_async_pend");
    exp_at(k + 34, SIG_MOV,   0,     "s6_async_mov");
    exp_at(k + 34, SIG_IDLE,  1,     "s6_async_idle");
    exp_at(k + 34, SIG_DIR,   1,     "s6_async_dir");
    exp_at(k + 34, SIG_DOOR,  0,     "s6_async_door");
    exp_at(k + 37, SIG_PEND,  0,     "s6_post_pend");
    exp_at(k + 37, SIG_IDLE,  1,     "s6_post_idle");
    end_pulse();
    wait_until(k + 33);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_until(k + 38);

    // 6b: holding the call at the open floor keeps the door open.
    start_pulse(8'h20, k);
    exp_at(k + 51, SIG_DOOR, 1, "s6_hold_door_open");
    exp_at(k + 55, SIG_PEND, 0, "s6_hold_pend0");
    exp_at(k + 56, SIG_DOOR, 1, "s6_hold_extend");
    exp_at(k + 60, SIG_DOOR, 1, "s6_hold_last");
    exp_at(k + 61, SIG_DOOR, 0, "s6_hold_closed");
    exp_at(k + 61, SIG_IDLE, 1, "s6_hold_idle");
    end_pulse();
    wait_until(k + 51);
    req = 8'h20;
    wait_until(k + 57);
    req = '0;
    wait_until(k + 63);

    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d unchecked, expected 0", sbq.size());
      errors += sbq.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
